// File: rtl/register_pkg.sv
// register_pkg: definitions shared by the load_register family of storage
// registers.
//   DEFAULT_SIZE   : default data width of a register.
//   MAX_SIZE       : widest supported register.
//   data_t         : widest data container. Narrower registers zero-extend into
//                    it when they call the helpers below.
//   size_is_legal  : elaboration-time width check (1..MAX_SIZE).
//   parity_of      : even-parity helper. It is the XOR reduce of a data_t.
//                    Zero-extension does not change the result.
package register_pkg;

    localparam int unsigned DEFAULT_SIZE = 32'd32;
    localparam int unsigned MAX_SIZE     = 32'd128;

    typedef logic [MAX_SIZE-1:0] data_t;

    function automatic bit size_is_legal(input int unsigned size);
        return (size >= 32'd1) && (size <= MAX_SIZE);
    endfunction

    function automatic logic parity_of(input data_t value);
        return ^value;
    endfunction

endpackage

// File: rtl/load_register_if.sv
// load_register_if: data and status bundle of a load_register.
//   load     : capture enable (master -> slave)
//   data_i   : data to capture (master -> slave)
//   data_o   : stored value (slave -> master)
//   loaded_o : at least one load since the last reset (slave -> master)
//   parity_o : even parity of data_o. It exists only when
//              LOAD_REGISTER_PARITY_EN is defined.
// The master modport is the user of the register. The slave modport is the
// register itself.
interface load_register_if
    import register_pkg::*;
#(
    parameter int unsigned Size = DEFAULT_SIZE
);

    logic            load;
    logic [Size-1:0] data_i;
    logic [Size-1:0] data_o;
    logic            loaded_o;
`ifdef LOAD_REGISTER_PARITY_EN
    logic            parity_o;
`endif

    modport master (
        output load,
        output data_i,
        input  data_o,
        input  loaded_o
`ifdef LOAD_REGISTER_PARITY_EN
        , input parity_o
`endif
    );

    modport slave (
        input  load,
        input  data_i,
        output data_o,
        output loaded_o
`ifdef LOAD_REGISTER_PARITY_EN
        , output parity_o
`endif
    );

endinterface

// File: rtl/load_register_parity_chk.sv
// load_register_parity_chk: simulation-only consistency monitor for the
// registered parity bit of load_register.
//   clk      : register clock
//   reset    : synchronous active-high reset. The check is disabled during reset.
//   data_q   : stored value
//   parity_q : stored parity bit
// The monitor flags any cycle where parity_q differs from ^data_q.
// This module is compiled only when LOAD_REGISTER_PARITY_EN is defined.
`ifdef LOAD_REGISTER_PARITY_EN
module load_register_parity_chk
    import register_pkg::*;
#(
    parameter int unsigned Size = DEFAULT_SIZE
) (
    input logic            clk,
    input logic            reset,
    input logic [Size-1:0] data_q,
    input logic            parity_q
);

`ifndef SYNTHESIS
    // The stored parity must always match the stored data once it is defined.
    property p_parity_consistent;
        @(posedge clk) disable iff (reset)
            !$isunknown(data_q) |-> (parity_q == parity_of(data_t'(data_q)));
    endproperty

    a_parity_consistent: assert property (p_parity_consistent)
        else $error("load_register parity bit disagrees with stored data");
`endif

endmodule
`endif

// File: rtl/parity_gen.sv
// parity_gen: purely combinational even-parity generator over Size bits.
//   data_i   : word to protect
//   parity_o : XOR reduce of data_i
// This module is compiled only when LOAD_REGISTER_PARITY_EN is defined. The
// default build therefore carries no unused module.
`ifdef LOAD_REGISTER_PARITY_EN
module parity_gen
    import register_pkg::*;
#(
    parameter int unsigned Size = DEFAULT_SIZE
) (
    input  logic [Size-1:0] data_i,
    output logic            parity_o
);

    assign parity_o = parity_of(data_t'(data_i));

endmodule
`endif

// File: rtl/load_register.sv
// load_register: generic Size-bit load-enabled storage register.
// The register captures bus.data_i on a rising clk edge when bus.load is high.
// Otherwise it holds its contents. A synchronous reset loads ResetValue.
//   Size       : data width, 1..MAX_SIZE (default DEFAULT_SIZE)
//   ResetValue : value loaded by reset
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous active-high reset. It has priority over load.
//   bus        : load_register_if slave (load, data_i, data_o, loaded_o
//                and, optionally, parity_o)
// Optional feature macro: LOAD_REGISTER_PARITY_EN adds a registered
// even-parity bit (bus.parity_o) and a simulation-only consistency monitor.
// All outputs come straight from flops, so no input has a combinational path
// to an output.
module load_register
    import register_pkg::*;
#(
    parameter int unsigned     Size       = DEFAULT_SIZE,
    parameter logic [Size-1:0] ResetValue = {Size{1'b0}}
) (
    input logic              clk,
    input logic              reset,
    load_register_if.slave   bus
);

    // Reject illegal widths while the design is being elaborated.
    if (!size_is_legal(Size)) begin : g_size_check
        $fatal(1, "load_register: Size must be in 1..MAX_SIZE");
    end

    logic [Size-1:0] data_q;
    logic [Size-1:0] data_d;
    logic            loaded_q;
    logic            loaded_d;

`ifdef LOAD_REGISTER_PARITY_EN
    localparam logic ResetParity = parity_of(data_t'(ResetValue));

    logic parity_q;
    logic parity_d;

    // Parity follows data_d. The parity is therefore stored together with the
    // data on a load, and it is recomputed from the unchanged data on a hold.
    parity_gen #(
        .Size     (Size)
    ) u_parity_gen (
        .data_i   (data_d),
        .parity_o (parity_d)
    );
`endif

    // Next-state selection. The input bus is used only when load is high.
    // Undefined data on a non-loading cycle therefore never reaches the flops.
    always_comb begin
        data_d   = data_q;
        loaded_d = loaded_q;
        if (bus.load) begin
            data_d   = bus.data_i;
            loaded_d = 1'b1;
        end else begin
            data_d   = data_q;
            loaded_d = loaded_q;
        end
    end

    // State register: the synchronous reset wins over any simultaneous load.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= ResetValue;
            loaded_q <= 1'b0;
`ifdef LOAD_REGISTER_PARITY_EN
            parity_q <= ResetParity;
`endif
        end else begin
            data_q   <= data_d;
            loaded_q <= loaded_d;
`ifdef LOAD_REGISTER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.data_o   = data_q;
    assign bus.loaded_o = loaded_q;

`ifdef LOAD_REGISTER_PARITY_EN
    assign bus.parity_o = parity_q;

`ifndef SYNTHESIS
    load_register_parity_chk #(
        .Size     (Size)
    ) u_parity_chk (
        .clk      (clk),
        .reset    (reset),
        .data_q   (data_q),
        .parity_q (parity_q)
    );
`endif
`endif

endmodule

// File: tb/tb_load_register.sv
// tb_load_register: self-checking bench for load_register (Size=32, ResetValue=0).
// A constant vector table covers reset, load, hold and mid-stream reset.
// Hand-written sequences cover long holds and undefined data while idle.
// Randomized traffic is checked against a history-based reference model.
// In the model, the stored value is the most recent word loaded since the
// last reset. With no load since reset, it is the reset value.
module tb_load_register;

    localparam logic [31:0] RESET_VAL = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    load_register_if #(.Size(32)) bus ();

    load_register #(
        .Size       (32),
        .ResetValue (RESET_VAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: words loaded since the last reset.
    logic [31:0] hist_q[$];
    bit          model_valid = 1'b0;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [31:0] din;
        logic [31:0] exp_d;
        logic        exp_l;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] model_data();
        return (hist_q.size() == 0) ? RESET_VAL : hist_q[$];
    endfunction

    function automatic logic model_loaded();
        return hist_q.size() != 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus. Before the edge, the bench confirms that the
    // new inputs have not already changed the outputs. After the edge, it
    // updates the model.
    task automatic step(input logic r, input logic l, input logic [31:0] d);
        @(negedge clk);
        reset    = r;
        bus.load = l;
        bus.data_i = d;
        #1;
        if (model_valid) begin
            chk("nocomb_data", bus.data_o, model_data());
            chk("nocomb_loaded", {31'b0, bus.loaded_o}, {31'b0, model_loaded()});
        end
        @(posedge clk);
        #1;
        if (r) begin
            hist_q.delete();
            model_valid = 1'b1;
        end else if (l) begin
            hist_q.push_back(d);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, "_data"}, bus.data_o, model_data());
        chk({name, "_loaded"}, {31'b0, bus.loaded_o}, {31'b0, model_loaded()});
`ifdef LOAD_REGISTER_PARITY_EN
        chk({name, "_parity"}, {31'b0, bus.parity_o},
            {31'b0, logic'($countones(model_data()) % 2)});
`endif
    endtask

    initial begin
        logic [31:0] r_data;

        bus.load   = 1'b0;
        bus.data_i = 32'h0;

        vecs[0]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h12345678, 32'h12345678, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 32'hA5A5A5A5, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h00000000, 32'hA5A5A5A5, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h5A5A5A5A, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h5A5A5A5A, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h00000007, 32'h00000007, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h00000003, 32'h00000003, 1'b1};

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].din);
            chk($sformatf("vec%0d_data", i), bus.data_o, vecs[i].exp_d);
            chk($sformatf("vec%0d_loaded", i), {31'b0, bus.loaded_o}, {31'b0, vecs[i].exp_l});
        end

`ifdef LOAD_REGISTER_PARITY_EN
        // Directed parity cases.
        step(1'b0, 1'b1, 32'h00000007);
        chk("parity_7", {31'b0, bus.parity_o}, 32'd1);
        step(1'b0, 1'b1, 32'h00000003);
        chk("parity_3", {31'b0, bus.parity_o}, 32'd0);
        step(1'b1, 1'b0, 32'hFFFFFFFF);
        chk("parity_reset", {31'b0, bus.parity_o}, 32'd0);
`endif

        // Long hold with changing data and load low.
        step(1'b0, 1'b1, 32'hCAFEF00D);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, $urandom());
        end
        chk("long_hold_data", bus.data_o, 32'hCAFEF00D);
        chk_model("long_hold");

        // Undefined data while idle must not reach the register.
        step(1'b0, 1'b0, 32'hxxxxxxxx);
        chk("x_idle_data", bus.data_o, 32'hCAFEF00D);

        // Reset released with load high: the first edge with reset low captures.
        step(1'b1, 1'b1, 32'h0BADC0DE);
        chk_model("rst_rel_a");
        step(1'b0, 1'b1, 32'h0BADC0DE);
        chk("rst_rel_capture", bus.data_o, 32'h0BADC0DE);

        // Random load/hold pairs.
        for (int i = 0; i < 1000; i++) begin
            r_data = $urandom();
            step(1'b0, 1'b1, r_data);
            chk_model("rnd_load");
            step(1'b0, 1'b0, $urandom());
            chk("rnd_hold", bus.data_o, r_data);
        end

        // Random mix of reset, load and idle.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(1) == 1), $urandom());
            chk_model("rnd_mix");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
